uart_port_ctrl: RTL
===================

// Module: uart_port_ctrl
// PURPOSE
// - Drives the board's CPLD UART (rdn/wrn/data_ready/tbre/tsre) for the memory stage; the UART shares the ram1_data bus.
// - Sits between MemoryModule's MEM-stage request (Address/MemRead/MemWrite) and the pins.
// - Decodes the data and status addresses and runs the read/write strobe handshake.
// - Holds no_stop low, freezing the pipeline clock, until the access completes.
// PARAMETERS
// DATA_ADDR    16'hBF00  UART data register address (read = rx byte, write = tx byte)
// STAT_ADDR    16'hBF01  UART status address: bit0 = tx ready, bit1 = rx data ready
// STROBE_CYC   2         cycles rdn/wrn are held low (>=1)
// TIMEOUT_CYC  1024      max cycles waiting on tbre/tsre before forced completion
// PORTS
// clk          in   1   clk2x domain clock, the free-running memory clock
// rst          in   1   asynchronous reset, active-low
// addr         in   16  MEM-stage address
// mem_read     in   1   MEM-stage read request, level, held while no_stop=0
// mem_write    in   1   MEM-stage write request, level, held while no_stop=0
// wdata        in   16  MEM-stage write data; low byte sent
// rdata        out  16  read result, valid in the cycle done=1
// done         out  1   one-cycle pulse at access completion
// no_stop      out  1   0 = stall the pipeline clock
// uart_sel     out  1   1 = the addr/request selects the UART (combinational from addr)
// ram1_en_n    out  1   forced 1 (RAM1 disabled) while the FSM is not IDLE
// bus_oe       out  1   1 = drive bus_dout onto ram1_data
// bus_dout     out  16  {8'h00, wdata[7:0]}
// bus_din      in   16  ram1_data as sampled
// data_ready   in   1   rx byte available (async, synchronized inside)
// tbre, tsre   in   1   tx buffer empty / tx shift register empty (async, synchronized inside)
// rdn, wrn     out  1   CPLD read / write strobes, active-low
// BEHAVIOUR
// - Reset (rst=0) values: state=IDLE, rdn=1, wrn=1, bus_oe=0, no_stop=1, done=0, rdata=0, ram1_en_n=0, timers=0.
// - Synchronizers: data_ready, tbre and tsre each pass through 2 flops; the FSM uses only the synchronized copies.
// - Status read (addr==STAT_ADDR & mem_read): no FSM and no stall.
//   - rdata = {14'b0, dr_s, tbre_s&tsre_s}, combinational; done=1 in the same cycle.
// - Data read (addr==DATA_ADDR & mem_read):
//   - IDLE->RD_LOW: assert rdn=0 and no_stop=0 for STROBE_CYC cycles.
//   - RD_LOW: capture bus_din[7:0] into rdata in the last low cycle, with rdata[15:8]=0.
//   - RD_LOW->RD_END: rdn=1 for one cycle, done=1, no_stop=1.
//   - RD_END->IDLE.
//   - Latency: STROBE_CYC+1 cycles.
//   - Software polls status first; the block does not wait on data_ready.
// - Data write (addr==DATA_ADDR & mem_write):
//   - IDLE->WR_SETUP: bus_oe=1, wrn=1 for one cycle (data setup).
//   - WR_SETUP->WR_LOW: wrn=0 for STROBE_CYC cycles, bus_oe=1.
//   - WR_LOW->WR_TBRE: wrn=1, bus_oe=0; wait for tbre_s=1.
//   - WR_TBRE->WR_TSRE: wait for tsre_s=1.
//   - WR_TSRE->WR_END: done=1, no_stop=1.
//   - WR_END->IDLE.
//   - no_stop=0 from WR_SETUP through WR_TSRE.
// - Timeout: a counter runs in WR_TBRE/WR_TSRE. If it reaches TIMEOUT_CYC-1, go to WR_END anyway. The counter saturates and does not wrap.
// - mem_read & mem_write both set: treated as a read; the write is ignored.
// - Status write: ignored; done pulses with no strobe and no stall.
// - Non-UART addresses: uart_sel=0, no strobes, outputs stay idle.
// - After WR_END/RD_END the FSM spends one IDLE cycle before accepting a new request. This prevents a held request from re-triggering before the pipeline advances.
// - Reset mid-access returns to IDLE at once with rdn=wrn=1 and bus_oe=0. The access is lost, and no_stop=1 so the clock releases.
// - Bus contention rule: bus_oe=1 only in WR_SETUP/WR_LOW. bus_oe and rdn=0 are never both active.
// STRUCTURE
// - Shared package (uart_pkg): state encoding (IDLE, RD_LOW, RD_END, WR_SETUP, WR_LOW, WR_TBRE, WR_TSRE, WR_END) and the DATA_ADDR/STAT_ADDR constants, which MemoryModule also uses.
// - Sub-module sync2: a 2-flop synchronizer with asynchronous active-low reset to 0, instantiated 3 times.
// - The FSM, strobe counter and timeout counter live in this module.
// TESTING
// - Status: data_ready=1, tbre=tsre=1, read 0xBF01 -> rdata=16'h0003 with done in the same cycle, no_stop stays 1.
// - Data read: bus_din=16'hA55A, read 0xBF00, STROBE_CYC=2 -> rdn low for exactly 2 cycles, rdata=16'h005A on done, no_stop low for 2 cycles.
// - Data write: wdata=16'h1241, tbre rises 5 cycles and tsre 8 cycles after wrn rises -> bus_dout=16'h0041, wrn low for 2 cycles, done only after tsre_s=1.
// - Timeout: write with tbre held 0, TIMEOUT_CYC=16 -> done after 16 wait cycles, state returns to IDLE, no_stop=1.
// - Reset mid-write: drop rst during WR_LOW -> same cycle rdn=wrn=1, bus_oe=0, no_stop=1; a fresh write afterwards completes normally.
// - Non-UART: read 0x4000 -> uart_sel=0, rdn=wrn=1, ram1_en_n=0, no stall.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART port definitions: FSM state encoding, register addresses and status-word packing.
// Also used by MemoryModule for address decode.
package uart_pkg;

    localparam logic [15:0] UART_DATA_ADDR   = 16'hBF00;
    localparam logic [15:0] UART_STAT_ADDR   = 16'hBF01;
    localparam int unsigned UART_STROBE_CYC  = 2;
    localparam int unsigned UART_TIMEOUT_CYC = 1024;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_LOW   = 3'd1,
        RD_END   = 3'd2,
        WR_SETUP = 3'd3,
        WR_LOW   = 3'd4,
        WR_TBRE  = 3'd5,
        WR_TSRE  = 3'd6,
        WR_END   = 3'd7
    } uart_state_e;

    // Status word: bit1 = rx byte waiting, bit0 = transmitter fully drained.
    function automatic logic [15:0] uart_status(input logic rx_rdy, input logic tx_rdy);
        return {14'b0, rx_rdy, tx_rdy};
    endfunction

endpackage

// File: rtl/uart_port_ctrl_sync2.sv
// Two-flop synchronizer for a single asynchronous level; one cycle of metastability settling, no backpressure.
// Resets to 0 so an idle CPLD line reads as "not ready" right after reset.
module sync2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/uart_port_ctrl.sv
// MEM-stage controller for the CPLD UART on the shared ram1_data bus; data reads finish STROBE_CYC+1 cycles after acceptance.
// Holds o_no_stop low (pipeline clock frozen) through strobes and tx drain; status accesses complete combinationally.
module uart_port_ctrl
    import uart_pkg::*;
#(
    parameter logic [15:0] DATA_ADDR   = UART_DATA_ADDR,
    parameter logic [15:0] STAT_ADDR   = UART_STAT_ADDR,
    parameter int unsigned STROBE_CYC  = UART_STROBE_CYC,
    parameter int unsigned TIMEOUT_CYC = UART_TIMEOUT_CYC
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_addr,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_rdata,
    output logic        o_done,
    output logic        o_no_stop,
    output logic        o_uart_sel,
    output logic        o_ram1_en_n,
    output logic        o_bus_oe,
    output logic [15:0] o_bus_dout,
    input  logic [15:0] i_bus_din,
    input  logic        i_data_ready,
    input  logic        i_tbre,
    input  logic        i_tsre,
    output logic        o_rdn,
    output logic        o_wrn
);

    localparam int SCW = (STROBE_CYC  > 1) ? $clog2(STROBE_CYC)  : 1;
    localparam int TOW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [SCW-1:0] STRB_LAST = SCW'(STROBE_CYC - 1);
    localparam logic [TOW-1:0] TMO_LAST  = TOW'(TIMEOUT_CYC - 1);

    uart_state_e    r_state;
    uart_state_e    w_state_nxt;
    logic           r_guard;
    logic [SCW-1:0] r_strb_cnt;
    logic [TOW-1:0] r_tmo_cnt;
    logic [15:0]    r_rdata;

    logic w_dr_s;
    logic w_tbre_s;
    logic w_tsre_s;
    logic w_is_data;
    logic w_is_stat;
    logic w_stat_acc;
    logic w_stat_rd;
    logic w_rd_req;
    logic w_wr_req;
    logic w_accept;
    logic w_strb_last;
    logic w_tmo;
    logic w_strobe_st;
    logic w_wait_st;
    logic w_rdn;
    logic w_wrn;
    logic w_bus_oe;
    logic w_no_stop;
    logic w_done;
    logic w_unused;

    sync2 u_sync_dr   (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_data_ready), .o_q(w_dr_s));
    sync2 u_sync_tbre (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_tbre),       .o_q(w_tbre_s));
    sync2 u_sync_tsre (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_tsre),       .o_q(w_tsre_s));

    assign w_is_data  = (i_addr == DATA_ADDR);
    assign w_is_stat  = (i_addr == STAT_ADDR);
    assign w_stat_acc = (r_state == IDLE) && w_is_stat && (i_mem_read || i_mem_write);
    assign w_stat_rd  = w_stat_acc && i_mem_read;
    // A simultaneous read and write is treated as a read.
    assign w_rd_req   = w_is_data && i_mem_read;
    assign w_wr_req   = w_is_data && i_mem_write && !i_mem_read;
    // r_guard blocks the still-held request in the IDLE cycle right after completion.
    assign w_accept   = (r_state == IDLE) && !r_guard;

    assign w_strb_last = (r_strb_cnt == STRB_LAST);
    assign w_tmo       = (r_tmo_cnt == TMO_LAST);
    assign w_strobe_st = (r_state == RD_LOW) || (r_state == WR_LOW);
    assign w_wait_st   = (r_state == WR_TBRE) || (r_state == WR_TSRE);

    always_comb begin
        w_state_nxt = r_state;
        w_rdn       = 1'b1;
        w_wrn       = 1'b1;
        w_bus_oe    = 1'b0;
        w_no_stop   = 1'b1;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                w_done = w_stat_acc;
                if (w_accept && w_rd_req) begin
                    w_state_nxt = RD_LOW;
                end else if (w_accept && w_wr_req) begin
                    w_state_nxt = WR_SETUP;
                end
            end
            RD_LOW: begin
                w_rdn     = 1'b0;
                w_no_stop = 1'b0;
                if (w_strb_last) begin
                    w_state_nxt = RD_END;
                end
            end
            RD_END: begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            WR_SETUP: begin
                w_bus_oe    = 1'b1;
                w_no_stop   = 1'b0;
                w_state_nxt = WR_LOW;
            end
            WR_LOW: begin
                w_wrn     = 1'b0;
                w_bus_oe  = 1'b1;
                w_no_stop = 1'b0;
                if (w_strb_last) begin
                    w_state_nxt = WR_TBRE;
                end
            end
            WR_TBRE: begin
                w_no_stop = 1'b0;
                if (w_tbre_s) begin
                    w_state_nxt = WR_TSRE;
                end else if (w_tmo) begin
                    w_state_nxt = WR_END;
                end
            end
            WR_TSRE: begin
                w_no_stop = 1'b0;
                if (w_tsre_s || w_tmo) begin
                    w_state_nxt = WR_END;
                end
            end
            WR_END: begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_guard    <= 1'b0;
            r_strb_cnt <= '0;
            r_tmo_cnt  <= '0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_guard <= (r_state == RD_END) || (r_state == WR_END);

            if (w_strobe_st && !w_strb_last) begin
                r_strb_cnt <= r_strb_cnt + 1'b1;
            end else begin
                r_strb_cnt <= '0;
            end

            // The drain timer is shared by both wait states and saturates rather than wrapping.
            if (w_wait_st) begin
                if (!w_tmo) begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                end
            end else begin
                r_tmo_cnt <= '0;
            end

            if ((r_state == RD_LOW) && w_strb_last) begin
                r_rdata <= {8'h00, i_bus_din[7:0]};
            end
        end
    end

    assign o_rdata     = w_stat_rd ? uart_status(w_dr_s, w_tbre_s & w_tsre_s) : r_rdata;
    assign o_done      = w_done;
    assign o_no_stop   = w_no_stop;
    assign o_uart_sel  = w_is_data || w_is_stat;
    assign o_ram1_en_n = (r_state != IDLE);
    assign o_bus_oe    = w_bus_oe;
    assign o_bus_dout  = {8'h00, i_wdata[7:0]};
    assign o_rdn       = w_rdn;
    assign o_wrn       = w_wrn;

    assign w_unused = &{1'b0, i_bus_din[15:8], i_wdata[15:8]};

endmodule
